// File: rtl/spi_slave_param.sv
// SPI slave front end: deserialises (DATA_W+2)-bit command frames from MOSI and
// serialises RAM read data onto MISO, flagging aborted or out-of-sequence frames.
module spi_slave_param #(
  parameter int DATA_W       = 8,
  parameter bit TX_MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);
  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE
  } state_e;

  state_e               state_reg, state_next;
  logic [FRAME_W-2:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [DATA_W-1:0]    tx_shift_reg, tx_shift_next;
  logic                 rd_flag_reg, rd_flag_next;
  logic                 miso_reg, miso_next;
  logic [FRAME_W-1:0]   rx_data_reg, rx_data_next;
  logic                 rx_valid_reg, rx_valid_next;
  logic                 frame_err_reg, frame_err_next;
  logic [FRAME_W-1:0]   frame_full;
  logic [DATA_W-1:0]    tx_ordered;

  // Reorder tx_data once so the shifter always sends from its top bit.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_order
    if (TX_MSB_FIRST) begin : g_msb
      assign tx_ordered[gi] = tx_data[gi];
    end else begin : g_lsb
      assign tx_ordered[gi] = tx_data[DATA_W-1-gi];
    end
  end

  assign frame_full = {shift_reg, MOSI};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      tx_shift_reg  <= '0;
      rd_flag_reg   <= 1'b0;
      miso_reg      <= 1'b0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      cnt_reg       <= cnt_next;
      tx_shift_reg  <= tx_shift_next;
      rd_flag_reg   <= rd_flag_next;
      miso_reg      <= miso_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    cnt_next       = cnt_reg;
    tx_shift_next  = tx_shift_reg;
    rd_flag_next   = rd_flag_reg;
    miso_next      = miso_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        miso_next = 1'b0;
        cnt_next  = '0;
        if (!SS_n) state_next = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n) begin
          frame_err_next = 1'b1;
          miso_next      = 1'b0;
          state_next     = IDLE;
        end else begin
          shift_next = frame_full[FRAME_W-2:0];
          cnt_next   = CNT_W'(1);
          if (!MOSI)           state_next = WRITE;
          else if (rd_flag_reg) state_next = READ_DATA;
          else                 state_next = READ_ADD;
        end
      end
      WRITE, READ_ADD, READ_DATA: begin
        shift_next = frame_full[FRAME_W-2:0];
        cnt_next   = cnt_reg + CNT_W'(1);
        if (cnt_reg == LAST_RX) begin
          // Read commands must alternate: address (10) then data (11).
          if (state_reg == WRITE || frame_full[FRAME_W-2] == rd_flag_reg) begin
            rx_data_next  = frame_full;
            rx_valid_next = 1'b1;
            if (state_reg == READ_ADD) rd_flag_next = 1'b1;
            state_next = (state_reg == READ_DATA) ? WAIT_TX : DONE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = DONE;
          end
          if (SS_n) state_next = IDLE;
        end else if (SS_n) begin
          frame_err_next = 1'b1;
          miso_next      = 1'b0;
          state_next     = IDLE;
        end
      end
      WAIT_TX: begin
        if (SS_n) begin
          frame_err_next = 1'b1;
          miso_next      = 1'b0;
          state_next     = IDLE;
        end else if (tx_valid) begin
          miso_next     = tx_ordered[DATA_W-1];
          tx_shift_next = {tx_ordered[DATA_W-2:0], 1'b0};
          cnt_next      = CNT_W'(1);
          state_next    = SEND;
        end
      end
      SEND: begin
        if (SS_n) begin
          frame_err_next = 1'b1;
          miso_next      = 1'b0;
          state_next     = IDLE;
        end else if (cnt_reg == LAST_TX) begin
          miso_next    = 1'b0;
          rd_flag_next = 1'b0;
          state_next   = DONE;
        end else begin
          miso_next     = tx_shift_reg[DATA_W-1];
          tx_shift_next = {tx_shift_reg[DATA_W-2:0], 1'b0};
          cnt_next      = cnt_reg + CNT_W'(1);
        end
      end
      DONE: begin
        miso_next = 1'b0;
        if (SS_n) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign MISO      = miso_reg;
  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: doc/spi_slave_param.md
# spi_slave_param

Parametrised second-generation SPI slave front end for the SPI-to-RAM wrapper. It deserialises MOSI frames of `DATA_W+2` bits, where the 2-bit command is followed by the payload, and presents each complete frame on `rx_data` with a single-cycle `rx_valid`. For read-data commands it waits for the RAM's `tx_valid` and serialises `tx_data` onto MISO in a configurable bit order. Compared with the first-generation slave it adds:
- a configurable payload width;
- a configurable MISO bit order;
- command/sequence checking;
- abort detection, reported on `frame_err`.

## Interface
Parameters:
- `DATA_W`, default 8: payload width, minimum 2. Frame width is `FRAME_W = DATA_W+2`.
- `TX_MSB_FIRST`, default 1: 1 sends `tx_data[DATA_W-1]` first on MISO; 0 sends `tx_data[0]` first.

Ports (reset is asynchronous and active-low):
- `clk`  in  1  single clock; MOSI is sampled and MISO is updated on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `SS_n`  in  1  slave select, active low.
- `MOSI`  in  1  serial data in.
- `tx_valid`  in  1  `tx_data` is valid for the pending read.
- `tx_data`  in  `DATA_W`  read data from RAM.
- `MISO`  out  1  serial data out.
- `rx_data`  out  `FRAME_W`  last complete frame: `[FRAME_W-1:FRAME_W-2]` is the command, `[DATA_W-1:0]` is the payload.
- `rx_valid`  out  1  one-cycle strobe for a new `rx_data`.
- `frame_err`  out  1  one-cycle strobe for an aborted or illegal frame.
- `busy`  out  1  high whenever the FSM is not in IDLE (combinational from state).

## Operation
- **Commands:**
  - 00: write address.
  - 01: write data.
  - 10: read address.
  - 11: read data.
- **Frame sampling:** bits are sampled MSB first (first bit goes to `rx_data[FRAME_W-1]`). Bit 0 of the frame is sampled in CHK_CMD; the remaining `FRAME_W-1` bits are sampled in the destination state.
- **States:** IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE.
- **IDLE:** `SS_n`=0 moves to CHK_CMD. The bit counter clears and MISO=0.
- **CHK_CMD:** MOSI=0 moves to WRITE. MOSI=1 moves to READ_ADD if `rd_flag`=0, or to READ_DATA if `rd_flag`=1.
- **WRITE / READ_ADD / READ_DATA:** shift MOSI until `FRAME_W` bits have been taken. On completion:
  - `rx_data` loads the frame and `rx_valid` pulses.
  - WRITE moves to DONE.
  - READ_ADD sets `rd_flag` and moves to DONE.
  - READ_DATA moves to WAIT_TX.
- **Illegal frame:** the second command bit must equal `rd_flag`, i.e. 10 only when `rd_flag`=0 and 11 only when `rd_flag`=1. On a mismatch:
  - `frame_err` pulses instead of `rx_valid`.
  - `rx_data` and `rd_flag` are unchanged.
  - The FSM moves to DONE.
- **WAIT_TX:** on the first edge with `tx_valid`=1:
  - `tx_data` is latched.
  - MISO loads the first bit.
  - The FSM moves to SEND.
- **SEND:** the remaining `DATA_W-1` bits are shifted out, one per edge. On the following edge MISO goes to 0, `rd_flag` clears and the FSM moves to DONE. `tx_data` changes after the latch are ignored.
- **DONE:** further MOSI bits are ignored and MISO holds 0 until `SS_n`=1.
- **SS_n=1 in any non-IDLE state:** the FSM returns to IDLE on that edge.
  - If taken in CHK_CMD, a data state with a partial frame, WAIT_TX or SEND, `frame_err` pulses, the partial frame is discarded, there is no `rx_valid`, `rd_flag` is unchanged and MISO goes to 0.
  - If taken in DONE, there is no error.
- **`rx_valid` and `frame_err`** are never high in the same cycle.

## Timing
- **Reset values:**
  - MISO=0, `rx_valid`=0, `frame_err`=0, `rx_data`=0, `busy`=0.
  - FSM in IDLE, `rd_flag`=0, counters 0.
  - Reset mid-frame takes effect immediately and asynchronously.
- **Frame timing:**
  - Edge e0 samples `SS_n`=0 and the FSM moves to CHK_CMD.
  - Edges e1..e`FRAME_W` sample frame bits 0..`FRAME_W-1`.
  - `rx_valid` (or `frame_err`) is high in the cycle after e`FRAME_W`, with `rx_data` updated in that same cycle.
- **Read timing:**
  - If the `tx_valid` edge is t, MISO carries bit k in the cycle after edge t+k, for k=0..`DATA_W-1`.
  - MISO=0 from edge t+`DATA_W`.
  - The earliest t is one edge after the READ_DATA frame completes.
- **Hold behaviour:** `rx_data` holds between frames, including through IDLE. `tx_valid` may stay high; only its first sample in WAIT_TX matters.
- **`SS_n` timing:** `SS_n` rising on the same edge as the last frame bit still completes the frame normally (`rx_valid`, no error), then the FSM goes to IDLE.

## Test plan
- **Write frame:** `DATA_W`=8, frame 00_1010_0101 → `rx_data`=10'h0A5, `rx_valid` for exactly 1 cycle, 11 cycles after the `SS_n` fall, `frame_err`=0.
- **Read address then read data:** frame 10_0000_0011, then frame 11_xxxx_xxxx, `tx_valid`=1 with `tx_data`=8'h3C → MISO 0,0,1,1,1,1,0,0 in consecutive cycles, then 0; `rd_flag` returns to 0.
- **Abort:** `SS_n` rises after 5 bits of a write frame → `frame_err` 1 cycle, no `rx_valid`, `rx_data` unchanged, `busy`=0 the next cycle.
- **Sequence error:** with `rd_flag`=0, send frame 11_… → `frame_err`, no `rx_valid`, `rd_flag` stays 0, MISO stays 0.
- **Width and bit order:** `DATA_W`=16, `TX_MSB_FIRST`=0, read of `tx_data`=16'h8001 → MISO 1, then fourteen 0s, then 1, with LSB first.
- **Reset mid-read:** `rst_n` asserted mid-SEND → MISO=0 and `busy`=0 immediately; a new read-data frame is treated as sequence error (`rd_flag`=0).
